// File: rtl/tlp_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tlp_reg_responder (with tlp_xcvr_pkg)
// Description : Target-side TLP responder on the 64-bit Avalon-ST pipes.
//               It decodes single-DW 3DW MWr32/MRd32 requests hitting BAR0.
//               It maintains a small 32-bit register file. Every accepted
//               read gets a CplD on the tx pipe. All other TLPs are drained
//               to EOP with no side effects.
// Ports       : pcieClk_in/pcieRst_in   clock, sync active-high reset
//               cfgBusDev_in            bus/device number (completer ID)
//               rxData_in/rxSOP_in/rxEOP_in/rxValid_in/rxReady_out
//                                        Host->FPGA request pipe
//               txData_out/txSOP_out/txEOP_out/txValid_out/txReady_in
//                                        FPGA->Host completion pipe
// Revision    : 1.0 - initial release
// ============================================================================

package tlp_xcvr_pkg;
  // 8-bit bus number plus 5-bit device number.
  typedef logic [12:0] BusID;

  typedef enum logic [2:0] {
    SOP_NONE = 3'd0,
    SOP_BAR0 = 3'd1,
    SOP_BAR1 = 3'd2,
    SOP_BAR2 = 3'd3,
    SOP_BAR3 = 3'd4,
    SOP_BAR4 = 3'd5,
    SOP_BAR5 = 3'd6
  } SopBar;
endpackage

module tlp_reg_responder #(
  parameter int NUM_REGS = 16
) (
  input  logic                      pcieClk_in,
  input  logic                      pcieRst_in,
  input  tlp_xcvr_pkg::BusID        cfgBusDev_in,
  input  logic [63:0]               rxData_in,
  input  tlp_xcvr_pkg::SopBar       rxSOP_in,
  input  logic                      rxEOP_in,
  input  logic                      rxValid_in,
  output logic                      rxReady_out,
  output logic [63:0]               txData_out,
  output logic                      txSOP_out,
  output logic                      txEOP_out,
  output logic                      txValid_out,
  input  logic                      txReady_in
);

  localparam int          IDX_W       = $clog2(NUM_REGS);
  localparam logic [7:0]  C_FMT_MWR32 = 8'h40;
  localparam logic [7:0]  C_FMT_MRD32 = 8'h00;
  localparam logic [31:0] C_CPL_DW0   = 32'h4A00_0001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR1  = 3'd1,
    WDATA = 3'd2,
    DRAIN = 3'd3,
    CPL0  = 3'd4,
    CPL1  = 3'd5,
    CPL2  = 3'd6
  } StateT;

  StateT             r_state;
  StateT             w_nextState;

  logic              r_rxReady;
  logic [63:0]       r_txData;
  logic              r_txSop;
  logic              r_txEop;
  logic              r_txValid;

  logic [7:0]        r_fmtType;
  logic [15:0]       r_reqId;
  logic [7:0]        r_tag;
  logic [3:0]        r_firstBe;
  logic [6:0]        r_addr;
  logic [31:0]       r_rdData;
  logic [31:0]       r_regs [NUM_REGS];

  logic              w_rxFire;
  logic              w_txFire;
  logic              w_isSop;
  logic              w_hdrAccept;
  logic              w_isRead;
  logic              w_rdLatch;
  logic              w_regWe;
  logic [IDX_W-1:0]  w_hdrIdx;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [31:0]       w_wrData;
  logic [31:0]       w_cplDw1;
  logic [31:0]       w_cplDw2;
  logic              w_unusedRx;

  assign rxReady_out = r_rxReady;
  assign txData_out  = r_txData;
  assign txSOP_out   = r_txSop;
  assign txEOP_out   = r_txEop;
  assign txValid_out = r_txValid;

  assign w_rxFire    = rxValid_in && r_rxReady;
  assign w_txFire    = r_txValid && txReady_in;
  assign w_isSop     = (rxSOP_in != tlp_xcvr_pkg::SOP_NONE);
  assign w_hdrAccept = ((rxData_in[31:24] == C_FMT_MWR32) || (rxData_in[31:24] == C_FMT_MRD32))
                       && (rxData_in[9:0] == 10'd1)
                       && (rxSOP_in == tlp_xcvr_pkg::SOP_BAR0);
  assign w_isRead    = (r_fmtType == C_FMT_MRD32);
  assign w_hdrIdx    = rxData_in[IDX_W+1:2];

  // Status is always successful, BCM clear, byte count fixed at one DW.
  assign w_cplDw1    = {cfgBusDev_in, 3'b000, 3'b000, 1'b0, 12'd4};
  assign w_cplDw2    = {r_reqId, r_tag, 1'b0, r_addr};

  // Header fields not needed for decode (reserved bits, upper address).
  assign w_unusedRx  = ^rxData_in;

  // --------------------------------------------------------------------------
  // Next-state and write-strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    w_rdLatch   = 1'b0;
    w_regWe     = 1'b0;
    w_wrIdx     = w_hdrIdx;
    w_wrData    = rxData_in[63:32];
    case (r_state)
      IDLE: begin
        if (w_rxFire && w_isSop) begin
          if (rxEOP_in)         w_nextState = IDLE;
          else if (w_hdrAccept) w_nextState = HDR1;
          else                  w_nextState = DRAIN;
        end
      end
      HDR1: begin
        if (w_rxFire) begin
          if (w_isRead) begin
            w_rdLatch   = 1'b1;
            w_nextState = CPL0;
          end else if (rxData_in[2]) begin
            // Data sits in the upper DW of the address beat.
            w_regWe     = 1'b1;
            w_nextState = IDLE;
          end else if (rxEOP_in) begin
            // 3-beat write truncated after the header: discard.
            w_nextState = IDLE;
          end else begin
            w_nextState = WDATA;
          end
        end
      end
      WDATA: begin
        if (w_rxFire) begin
          w_regWe     = 1'b1;
          w_wrIdx     = r_addr[IDX_W+1:2];
          w_wrData    = rxData_in[31:0];
          w_nextState = rxEOP_in ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (w_rxFire && rxEOP_in) w_nextState = IDLE;
      end
      CPL0: begin
        if (w_txFire) w_nextState = CPL1;
      end
      CPL1: begin
        if (w_txFire) w_nextState = r_addr[2] ? IDLE : CPL2;
      end
      CPL2: begin
        if (w_txFire) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) r_state <= IDLE;
    else            r_state <= w_nextState;
  end

  // --------------------------------------------------------------------------
  // Datapath: header capture, register file, completion beats
  // --------------------------------------------------------------------------
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      r_rxReady <= 1'b0;
      r_txData  <= '0;
      r_txSop   <= 1'b0;
      r_txEop   <= 1'b0;
      r_txValid <= 1'b0;
      r_fmtType <= '0;
      r_reqId   <= '0;
      r_tag     <= '0;
      r_firstBe <= '0;
      r_addr    <= '0;
      r_rdData  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      // Ready follows the next state so rx is closed in the same cycle a
      // completion becomes pending.
      r_rxReady <= !((w_nextState == CPL0) || (w_nextState == CPL1) ||
                     (w_nextState == CPL2));

      if ((r_state == IDLE) && w_rxFire && w_isSop) begin
        r_fmtType <= rxData_in[31:24];
        r_reqId   <= rxData_in[63:48];
        r_tag     <= rxData_in[47:40];
        r_firstBe <= rxData_in[35:32];
      end

      if ((r_state == HDR1) && w_rxFire) r_addr <= rxData_in[6:0];

      // Snapshot so later writes cannot disturb an in-flight completion.
      if (w_rdLatch) r_rdData <= r_regs[w_hdrIdx];

      if (w_regWe) begin
        for (int b = 0; b < 4; b++) begin
          if (r_firstBe[b]) r_regs[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
        end
      end

      if (w_rdLatch) begin
        r_txValid <= 1'b1;
        r_txSop   <= 1'b1;
        r_txEop   <= 1'b0;
        r_txData  <= {w_cplDw1, C_CPL_DW0};
      end else if (w_txFire) begin
        case (r_state)
          CPL0: begin
            r_txSop <= 1'b0;
            if (r_addr[2]) begin
              r_txData <= {r_rdData, w_cplDw2};
              r_txEop  <= 1'b1;
            end else begin
              r_txData <= {32'h0, w_cplDw2};
              r_txEop  <= 1'b0;
            end
          end
          CPL1: begin
            if (r_addr[2]) begin
              r_txValid <= 1'b0;
              r_txEop   <= 1'b0;
              r_txData  <= '0;
            end else begin
              r_txData  <= {32'h0, r_rdData};
              r_txEop   <= 1'b1;
            end
          end
          default: begin
            r_txValid <= 1'b0;
            r_txSop   <= 1'b0;
            r_txEop   <= 1'b0;
            r_txData  <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlp_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlp_reg_responder
// Description : Directed bench for tlp_reg_responder. Expected completion
//               beats come from a register model and are queued when a read
//               is issued, then popped as the tx pipe delivers beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlp_reg_responder;
  import tlp_xcvr_pkg::*;

  localparam logic [12:0] C_BUSDEV = 13'h1234;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } CplBeat;

  logic        clk;
  logic        rst;
  BusID        busDev;
  logic [63:0] rxData;
  SopBar       rxSop;
  logic        rxEop;
  logic        rxValid;
  logic        rxReady;
  logic [63:0] txData;
  logic        txSop;
  logic        txEop;
  logic        txValid;
  logic        txReady;

  int          total = 0;
  int          bad   = 0;
  CplBeat      q[$];
  logic [31:0] mdl [16];

  tlp_reg_responder #(.NUM_REGS(16)) dut (
    .pcieClk_in   (clk),
    .pcieRst_in   (rst),
    .cfgBusDev_in (busDev),
    .rxData_in    (rxData),
    .rxSOP_in     (rxSop),
    .rxEOP_in     (rxEop),
    .rxValid_in   (rxValid),
    .rxReady_out  (rxReady),
    .txData_out   (txData),
    .txSOP_out    (txSop),
    .txEOP_out    (txEop),
    .txValid_out  (txValid),
    .txReady_in   (txReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] fmt, input logic [9:0] len,
                                      input logic [15:0] reqId, input logic [7:0] tag,
                                      input logic [3:0] be);
    return {reqId, tag, 4'b0000, be, fmt, 14'b0, len};
  endfunction

  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic sendBeat(input logic [63:0] d, input SopBar sop, input logic eop);
    bit ok;
    ok      = 1'b0;
    rxData  = d;
    rxSop   = sop;
    rxEop   = eop;
    rxValid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rxReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else    check("rx_accept_timeout", 64'(ok), 64'd1);
    rxValid = 1'b0;
    rxSop   = SOP_NONE;
    rxEop   = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    sendBeat(hdr(8'h40, 10'd1, 16'h0200, 8'h22, be), SOP_BAR0, 1'b0);
    if (addr[2]) begin
      sendBeat({data, addr}, SOP_NONE, 1'b1);
    end else begin
      sendBeat({32'h0, addr}, SOP_NONE, 1'b0);
      sendBeat({32'h0, data}, SOP_NONE, 1'b1);
    end
    for (int b = 0; b < 4; b++)
      if (be[b]) mdl[addr[5:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic pushRead(input logic [31:0] addr, input logic [15:0] reqId, input logic [7:0] tag);
    logic [31:0] dw2;
    logic [31:0] data;
    CplBeat      e;
    data   = mdl[addr[5:2]];
    dw2    = {reqId, tag, 1'b0, addr[6:0]};
    e.data = {C_BUSDEV, 3'b000, 16'h0004, 32'h4A00_0001}; e.sop = 1'b1; e.eop = 1'b0;
    q.push_back(e);
    if (addr[2]) begin
      e.data = {data, dw2}; e.sop = 1'b0; e.eop = 1'b1; q.push_back(e);
    end else begin
      e.data = {32'h0, dw2}; e.sop = 1'b0; e.eop = 1'b0; q.push_back(e);
      e.data = {32'h0, data}; e.sop = 1'b0; e.eop = 1'b1; q.push_back(e);
    end
  endtask

  task automatic sendRead(input logic [31:0] addr, input logic [15:0] reqId, input logic [7:0] tag);
    pushRead(addr, reqId, tag);
    sendBeat(hdr(8'h00, 10'd1, reqId, tag, 4'hF), SOP_BAR0, 1'b0);
    sendBeat({32'h0, addr}, SOP_NONE, 1'b1);
    // One cycle after the address beat the completion must be presented.
    check("rd_latency_valid", 64'(txValid), 64'd1);
  endtask

  // Consume beats until EOP; optionally stall for 5 cycles once stallAt beats are taken.
  task automatic collect(input int stallAt);
    CplBeat      e;
    bit          done;
    int          beats;
    logic [63:0] hd;
    logic        hs;
    logic        he;
    done  = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (txValid && txReady) begin
        if (q.size() == 0) begin
          check("cpl_unexpected_beat", 64'd1, 64'd0);
          e = '0;
        end else begin
          e = q.pop_front();
        end
        check("cpl_data", txData, e.data);
        check("cpl_sop", 64'(txSop), 64'(e.sop));
        check("cpl_eop", 64'(txEop), 64'(e.eop));
        beats++;
        done = txEop;
        @(negedge clk);
        if (!done && beats == stallAt) begin
          txReady = 1'b0;
          hd = txData;
          hs = txSop;
          he = txEop;
          repeat (5) begin
            @(negedge clk);
            check("stall_data", txData, hd);
            check("stall_sop", 64'(txSop), 64'(hs));
            check("stall_eop", 64'(txEop), 64'(he));
            check("stall_valid", 64'(txValid), 64'd1);
            check("stall_rxready", 64'(rxReady), 64'd0);
          end
          txReady = 1'b1;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("cpl_done", 64'(done), 64'd1);
    check("cpl_valid_drop", 64'(txValid), 64'd0);
    check("cpl_queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic expectQuiet(input string tag);
    repeat (4) @(negedge clk);
    check(tag, 64'(txValid), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    busDev  = C_BUSDEV;
    rxData  = '0;
    rxSop   = SOP_NONE;
    rxEop   = 1'b0;
    rxValid = 1'b0;
    txReady = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_txvalid", 64'(txValid), 64'd0);
    check("rst_txsop", 64'(txSop), 64'd0);
    check("rst_txeop", 64'(txEop), 64'd0);
    check("rst_txdata", txData, 64'd0);
    check("rst_rxready", 64'(rxReady), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rxready", 64'(rxReady), 64'd1);

    // Basic 2-beat read
    sendRead(32'h04, 16'h0100, 8'h11);
    check("cpl_rxready_closed", 64'(rxReady), 64'd0);
    collect(-1);

    // 3-beat write then immediate read, with a tx stall mid-completion
    writeReg(32'h08, 32'hDEAD_BEEF, 4'hF);
    sendRead(32'h08, 16'h0100, 8'h12);
    collect(1);

    // Byte-enable merge on a 2-beat write
    writeReg(32'h0C, 32'hAAAA_AAAA, 4'hF);
    writeReg(32'h0C, 32'h1122_3344, 4'b0101);
    sendRead(32'h0C, 16'h0300, 8'h13);
    collect(-1);
    check("be_merge_model", 64'(mdl[3]), 64'h0000_0000_AA22_AA44);

    // Index wraps modulo the register count: 0x4C selects register 3
    sendRead(32'h4C, 16'h0300, 8'h14);
    collect(-1);

    // Unaccepted TLPs are drained without side effects
    sendBeat(hdr(8'h00, 10'd2, 16'h0100, 8'h20, 4'hF), SOP_BAR0, 1'b0);
    sendBeat({32'h0, 32'h04}, SOP_NONE, 1'b1);
    expectQuiet("drain_len2_no_cpl");

    sendBeat(hdr(8'h40, 10'd1, 16'h0100, 8'h21, 4'hF), SOP_BAR2, 1'b0);
    sendBeat({32'h5555_5555, 32'h14}, SOP_NONE, 1'b1);
    expectQuiet("drain_bar2_no_cpl");

    sendBeat(hdr(8'h20, 10'd1, 16'h0100, 8'h22, 4'hF), SOP_BAR0, 1'b0);
    sendBeat({32'h0000_0014, 32'h0000_0001}, SOP_NONE, 1'b1);
    expectQuiet("drain_mrd64_no_cpl");

    sendRead(32'h14, 16'h0100, 8'h23);
    collect(-1);

    // Reset while the second completion beat is presented
    sendRead(32'h08, 16'h0100, 8'h24);
    @(negedge clk);
    check("cpl1_valid_before_rst", 64'(txValid), 64'd1);
    check("cpl1_sop_before_rst", 64'(txSop), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txvalid", 64'(txValid), 64'd0);
    check("midrst_rxready", 64'(rxReady), 64'd0);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    sendRead(32'h08, 16'h0100, 8'h25);
    collect(-1);
    sendRead(32'h0C, 16'h0100, 8'h26);
    collect(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlp_reg_responder.md
# tlp_reg_responder

Target-side TLP responder for the 64-bit Avalon-ST pipes of `pcie_sv`. It consumes host-initiated TLPs on the Host->FPGA pipe and decodes single-DW 3DW memory writes and reads aimed at BAR0. It maintains a sixteen-entry 32-bit register file and returns a `CplD` for every accepted read on the FPGA->Host pipe. It is instantiated inside `pcie_app`, between the rx and tx pipes.

## Interface
- `NUM_REGS`, 16: register count; a power of two between 2 and 16; register index = `addr[log2(NUM_REGS)+1:2]`.
- `pcieClk_in` in 1: sole clock; all logic rising-edge.
- `pcieRst_in` in 1: reset; one clock, synchronous, active-high.
- `cfgBusDev_in` in `tlp_xcvr_pkg::BusID`: bus/device number; the completer ID is `{cfgBusDev_in, 3'b000}`.
- `rxData_in` in 64: Host->FPGA beat; DW0 = `[31:0]`.
- `rxSOP_in` in `tlp_xcvr_pkg::SopBar`: `SOP_NONE` marks a non-first beat; `SOP_BAR0`..`SOP_BAR5` marks the first beat and the BAR hit.
- `rxEOP_in` in 1: last beat.
- `rxValid_in` in 1, `rxReady_out` out 1: rx handshake; a beat transfers when both are high.
- `txData_out` out 64, `txSOP_out` out 1, `txEOP_out` out 1: completion beat.
- `txValid_out` out 1, `txReady_in` in 1: tx handshake; a beat transfers when both are high.

## Operation
- Header QW0: fmt/type = `rxData_in[31:24]`, length = `[9:0]`, requester ID = `[63:48]`, tag = `[47:40]`, first BE = `[35:32]`. QW1 `[31:0]` = address.
- Accepted TLPs:
  - `MWr32` (`8'h40`) or `MRd32` (`8'h00`).
  - `length == 1`.
  - SOP value `SOP_BAR0`.
- Any other TLP is drained to EOP with no side effects.
- Write data location:
  - `addr[2]=1`: data is QW1 `[63:32]`, 2-beat TLP.
  - `addr[2]=0`: data is QW2 `[31:0]`, 3-beat TLP.
- Writes honour first BE per byte lane.
- Reads ignore BE. The completion always returns the full DW with byte count 4.
- FSM states: `IDLE`, `HDR1`, `WDATA`, `DRAIN`, `CPL0`, `CPL1`, `CPL2`.
  - `IDLE`: transfer with SOP. Latch QW0, then go to `HDR1`. If that beat has EOP, go to `IDLE`. If the TLP is not accepted, go to `DRAIN`, or stay in `IDLE` when the beat has EOP.
  - `HDR1`:
    - MRd: latch address, read the register, go to `CPL0`.
    - MWr with `addr[2]=1`: write the register, go to `IDLE`.
    - MWr with `addr[2]=0`: go to `WDATA`.
    - If a 3-beat MWr shows EOP at QW1, discard it and go to `IDLE`.
  - `WDATA`: write QW2 `[31:0]`, then go to `IDLE`. If the beat lacks EOP, go to `DRAIN` after the write.
  - `DRAIN`: stay until a beat with EOP transfers, then go to `IDLE`.
  - `CPL0`..`CPL2`: emit the completion; return to `IDLE` after the EOP beat transfers.
- Completion format:
  - DW0 = `32'h4A000001`.
  - DW1 = `{cfgBusDev_in, 3'b000, 3'b000 status, 1'b0 BCM, 12'd4}`.
  - DW2 = `{reqID, tag, 1'b0, addr[6:0]}`.
  - DW3 = register data.
- Completion beats:
  - `addr[2]=1`: QW0 = `{DW1,DW0}`, QW1 = `{DW3,DW2}` with EOP; 2 beats.
  - `addr[2]=0`: QW0 = `{DW1,DW0}`, QW1 = `{32'h0,DW2}`, QW2 = `{32'h0,DW3}` with EOP; 3 beats.
- Register data is captured when the read is decoded. A later write to the same register does not alter an in-flight completion.

## Timing
- In the reset cycle and on the cycle after reset:
  - registers = 0; state = `IDLE`.
  - `rxReady_out` = 0.
  - `txValid_out`, `txSOP_out`, `txEOP_out` = 0; `txData_out` = 0.
- `rxReady_out` is 1 in `IDLE`, `HDR1`, `WDATA` and `DRAIN`, and 0 in `CPL*`. The register is updated so that no rx beat transfers while a completion is pending.
- Read latency: `txValid_out` rises on the cycle after the QW1 transfer of the MRd.
- Tx outputs are registered and held stable while `txValid_out && !txReady_in`.
- A beat advances only on `txValid_out && txReady_in`. Between beats of one completion `txValid_out` stays high; after EOP it drops unless the next completion is already latched (not possible here; it drops).
- `txSOP_out` is high only on QW0; `txEOP_out` is high only on the last beat.
- Write latency: the register is updated at the clock edge that transfers the data beat. A read TLP immediately following returns the new value.
- `rxValid_in` low in any state: hold state, no side effects.
- Reset mid-completion: `txValid_out` = 0 next cycle; the partial TLP is abandoned and the pipe restarts in `IDLE`.
- Address bits above the index and below bit 2 are ignored for decode; the index wraps modulo `NUM_REGS`.

## Test plan
- After reset, MRd32, BAR0, addr `0x04`, tag `0x11`, reqID `0x0100` -> 2-beat CplD:
  - QW0 = `{cfgBusDev,3'b000,16'h0004, 32'h4A000001}`.
  - QW1 = `{32'h0, 16'h0100, 8'h11, 8'h04}`.
- MWr32, addr `0x08`, data `0xDEADBEEF` on QW2, then MRd addr `0x08` -> 3-beat CplD:
  - QW1 = `{32'h0, DW2 with lowerAddr 0x08}`.
  - QW2 = `{32'h0, 32'hDEADBEEF}`.
- MWr32 with BE `4'b0101`, data `0x11223344`, onto register value `0xAAAAAAAA` -> a readback returns `0xAA22AA44`.
- Holding `txReady_in` low for 5 cycles mid-completion -> `txData_out`, `txSOP_out` and `txEOP_out` hold stable and `rxReady_out` stays 0; the completion completes once `txReady_in` rises.
- The following are drained with no write and no completion; a subsequent valid read still works:
  - MRd with length 2.
  - MWr hitting BAR2.
  - 4DW MRd64 (`8'h20`) spanning 2 beats.
- `pcieRst_in` asserted during `CPL1` -> `txValid_out` is 0 the next cycle and registers read back 0.
